// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg : shared state encoding and constants for uart_port_arb |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_LOW  = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RD_LOW  = 3'd3;
    localparam logic [2:0] RD_CAP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = IDLE,
        ST_WR_LOW  = WR_LOW,
        ST_WR_WAIT = WR_WAIT,
        ST_RD_LOW  = RD_LOW,
        ST_RD_CAP  = RD_CAP
    } state_t;

    localparam logic [11:0] WDOG_LIMIT = 12'd4095;

    // Pulse counters stop at terminal count instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_port_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_port_arb_if : requester, consumer and UART bus signals          |
// | Optional macro UART_ARB_TIMEOUT_EN adds tx_timeout.   Rev 1.0        |
// +----------------------------------------------------------------------+
interface uart_port_arb_if;
    logic       tx_req0;
    logic       tx_req1;
    logic [7:0] tx_data0;
    logic [7:0] tx_data1;
    logic       tx_ack0;
    logic       tx_ack1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       uart_wrn;
    logic       uart_rdn;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       uart_data_ready;
    logic       uart_tbre;
    logic       uart_tsre;
    logic       busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic       tx_timeout;

    modport slave (
        input  tx_req0, tx_req1, tx_data0, tx_data1, rx_ready,
               uart_dout, uart_data_ready, uart_tbre, uart_tsre,
        output tx_ack0, tx_ack1, rx_valid, rx_data, uart_wrn, uart_rdn,
               uart_din, busy, tx_timeout
    );
    modport master (
        output tx_req0, tx_req1, tx_data0, tx_data1, rx_ready,
               uart_dout, uart_data_ready, uart_tbre, uart_tsre,
        input  tx_ack0, tx_ack1, rx_valid, rx_data, uart_wrn, uart_rdn,
               uart_din, busy, tx_timeout
    );
`else
    modport slave (
        input  tx_req0, tx_req1, tx_data0, tx_data1, rx_ready,
               uart_dout, uart_data_ready, uart_tbre, uart_tsre,
        output tx_ack0, tx_ack1, rx_valid, rx_data, uart_wrn, uart_rdn,
               uart_din, busy
    );
    modport master (
        output tx_req0, tx_req1, tx_data0, tx_data1, rx_ready,
               uart_dout, uart_data_ready, uart_tbre, uart_tsre,
        input  tx_ack0, tx_ack1, rx_valid, rx_data, uart_wrn, uart_rdn,
               uart_din, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rr_arb2 : combinational two-requester round-robin arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rr_arb2 (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic      [1:0] grant
);

    // last_grant names the requester served most recently; the other one is preferred.
    always_comb begin
        grant = 2'b00;
        if (last_grant) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_port_arb : shares one UART between two tx requesters and one rx |
// | Optional macro UART_ARB_TIMEOUT_EN enables the WR_WAIT watchdog.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_port_arb
    import uart_arb_pkg::*;
#(
    parameter int WR_PULSE = 2,
    parameter int RD_PULSE = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_port_arb_if.slave  bus
);

    localparam logic [3:0] C_WR_PULSE = 4'(WR_PULSE);
    localparam logic [3:0] C_RD_PULSE = 4'(RD_PULSE);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last_grant;
    logic       r_gnt1;
    logic       r_wrn;
    logic       r_rdn;
    logic [7:0] r_din;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_ack0;
    logic       r_ack1;
    logic [1:0] w_grant;
    logic       w_tx_idle;
`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [11:0] C_WDOG_LAST = WDOG_LIMIT - 12'd1;
    logic [11:0] r_wdog;
    logic        r_tx_timeout;
`endif

    assign w_tx_idle = bus.uart_tbre & bus.uart_tsre;

    uart_rr_arb2 u_arb (
        .req        ({bus.tx_req1, bus.tx_req0}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_gnt1       <= 1'b0;
            r_wrn        <= 1'b1;
            r_rdn        <= 1'b1;
            r_din        <= 8'd0;
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog       <= 12'd0;
            r_tx_timeout <= 1'b0;
`endif
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_tx_timeout <= 1'b0;
`endif
            if (r_rx_valid && bus.rx_ready)
                r_rx_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Draining the receiver comes first so rx bytes are never overrun.
                    if (bus.uart_data_ready && !r_rx_valid) begin
                        r_state <= ST_RD_LOW;
                        r_rdn   <= 1'b0;
                        r_cnt   <= 4'd1;
                    end else if (w_tx_idle && (w_grant != 2'b00)) begin
                        r_state      <= ST_WR_LOW;
                        r_wrn        <= 1'b0;
                        r_cnt        <= 4'd1;
                        r_gnt1       <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_din        <= w_grant[1] ? bus.tx_data1 : bus.tx_data0;
                    end
                end
                ST_WR_LOW: begin
                    if (r_cnt == C_WR_PULSE) begin
                        r_state <= ST_WR_WAIT;
                        r_wrn   <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_ack0  <= ~r_gnt1;
                        r_ack1  <= r_gnt1;
`ifdef UART_ARB_TIMEOUT_EN
                        r_wdog  <= 12'd0;
`endif
                    end else begin
                        r_cnt <= sat_inc4(r_cnt);
                    end
                end
                ST_WR_WAIT: begin
                    // r_cnt != 0 keeps at least two cycles here before trusting tbre/tsre.
                    if ((r_cnt != 4'd0) && w_tx_idle) begin
                        r_state <= ST_IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_wdog == C_WDOG_LAST) begin
                        r_state      <= ST_IDLE;
                        r_tx_timeout <= 1'b1;
                    end
`endif
                    else begin
                        r_cnt <= sat_inc4(r_cnt);
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    r_wdog <= r_wdog + 12'd1;
`endif
                end
                ST_RD_LOW: begin
                    if (r_cnt == C_RD_PULSE) begin
                        r_state <= ST_RD_CAP;
                        r_rdn   <= 1'b1;
                    end else begin
                        r_cnt <= sat_inc4(r_cnt);
                    end
                end
                ST_RD_CAP: begin
                    r_rx_data  <= bus.uart_dout;
                    r_rx_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wrn   <= 1'b1;
                    r_rdn   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_ack0  = r_ack0;
    assign bus.tx_ack1  = r_ack1;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.uart_wrn = r_wrn;
    assign bus.uart_rdn = r_rdn;
    assign bus.uart_din = r_din;
    assign bus.busy     = (r_state != ST_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.tx_timeout = r_tx_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_port_arb : directed vector bench for uart_port_arb           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_port_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_port_arb_if bus ();

    uart_port_arb #(.WR_PULSE(2), .RD_PULSE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst, req0, req1;
        logic [7:0] d0, d1;
        logic       dr, tbre, tsre, rxr;
        logic [7:0] dout;
        logic       wrn, rdn;
        logic [7:0] din;
        logic       ack0, ack1, busy, rxv;
        logic [7:0] rxd;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_overlap = 0;

    always @(negedge clk)
        if (bus.uart_wrn === 1'b0 && bus.uart_rdn === 1'b0) n_overlap++;

    function automatic logic [21:0] obs();
        return {bus.uart_wrn, bus.uart_rdn, bus.uart_din, bus.tx_ack0, bus.tx_ack1,
                bus.busy, bus.rx_valid, bus.rx_data};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst                 = v.rst;
        bus.tx_req0         = v.req0;
        bus.tx_req1         = v.req1;
        bus.tx_data0        = v.d0;
        bus.tx_data1        = v.d1;
        bus.uart_data_ready = v.dr;
        bus.uart_tbre       = v.tbre;
        bus.uart_tsre       = v.tsre;
        bus.rx_ready        = v.rxr;
        bus.uart_dout       = v.dout;
    endtask

    int cnt_a;
    int cnt_b;

    initial begin
        rst = 1'b0;
        bus.tx_req0 = 0; bus.tx_req1 = 0; bus.tx_data0 = 0; bus.tx_data1 = 0;
        bus.uart_data_ready = 0; bus.uart_tbre = 1; bus.uart_tsre = 1;
        bus.rx_ready = 0; bus.uart_dout = 0;

        //           rst r0 r1 d0     d1     dr tbr tsr rxr dout  | wrn rdn din   a0 a1 bsy rxv rxd
        // single write of 55
        vq.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h55, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'h55, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h55, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'h55, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h55, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h55, 1, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h55, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h55, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h55, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h55, 0, 0, 0, 0, 8'h00});
        // round-robin A1, B2, A1 after a fresh reset
        vq.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hA1, 1, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hA1, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 0, 1, 8'hB2, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 0, 1, 8'hB2, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hB2, 0, 1, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hB2, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hB2, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 1, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hA1, 1, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'hA1, 8'hB2, 0, 1, 1, 0, 8'h00, 1, 1, 8'hA1, 0, 0, 0, 0, 8'h00});
        // read has priority over a simultaneous write request
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 1, 1, 1, 0, 8'h3C, 1, 0, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 1, 1, 1, 0, 8'h3C, 1, 0, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1, 8'hA1, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1, 8'hA1, 0, 0, 0, 1, 8'h3C});
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 0, 1, 8'h5A, 0, 0, 1, 1, 8'h3C});
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 0, 1, 8'h5A, 0, 0, 1, 1, 8'h3C});
        vq.push_back('{1, 1, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1, 8'h5A, 1, 0, 1, 1, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1, 8'h5A, 0, 0, 1, 1, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h5A, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1, 8'h5A, 0, 0, 0, 1, 8'h3C});
        // unread byte blocks the next read until consumed
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'hC3, 1, 1, 8'h5A, 0, 0, 0, 1, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'hC3, 1, 1, 8'h5A, 0, 0, 0, 1, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'hC3, 1, 1, 8'h5A, 0, 0, 0, 0, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'hC3, 1, 0, 8'h5A, 0, 0, 1, 0, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'hC3, 1, 0, 8'h5A, 0, 0, 1, 0, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'hC3, 1, 1, 8'h5A, 0, 0, 1, 0, 8'h3C});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'hC3, 1, 1, 8'h5A, 0, 0, 0, 1, 8'hC3});
        // reset during WR_LOW, then during RD_LOW
        vq.push_back('{1, 1, 0, 8'h77, 8'h00, 0, 1, 1, 1, 8'h00, 0, 1, 8'h77, 0, 0, 1, 0, 8'hC3});
        vq.push_back('{0, 1, 0, 8'h77, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h77, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h77, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h99, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00});
        vq.push_back('{0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h99, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'h99, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        // request withdrawn while UART not ready: never served
        vq.push_back('{1, 0, 1, 8'h00, 8'h66, 0, 0, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h00, 8'h66, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h00, 8'h66, 0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00});
        // WR_WAIT holds until tbre and tsre are both high
        vq.push_back('{1, 1, 0, 8'h11, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'h11, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h11, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'h11, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 1, 0, 8'h11, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h11, 1, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h11, 8'h00, 0, 0, 1, 0, 8'h00, 1, 1, 8'h11, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h11, 8'h00, 0, 0, 1, 0, 8'h00, 1, 1, 8'h11, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h11, 8'h00, 0, 1, 0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 1, 0, 8'h00});
        vq.push_back('{1, 0, 0, 8'h11, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 8'h11, 0, 0, 0, 0, 8'h00});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(obs()),
                  32'({vq[i].wrn, vq[i].rdn, vq[i].din, vq[i].ack0, vq[i].ack1,
                       vq[i].busy, vq[i].rxv, vq[i].rxd}));
        end

        // Write strobe width and single ack over a whole transfer
        @(negedge clk);
        bus.tx_req0 = 1; bus.tx_data0 = 8'hE7; bus.uart_tbre = 1; bus.uart_tsre = 1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.uart_wrn === 1'b0) cnt_a++;
            if (bus.tx_ack0 === 1'b1) begin
                cnt_b++;
                bus.tx_req0 = 0;
            end
        end
        check("wr_low_cycles", 32'(cnt_a), 32'd2);
        check("ack0_pulses", 32'(cnt_b), 32'd1);

        // Read strobe width; data_ready stays high, the unread byte must block a second read
        @(negedge clk);
        bus.uart_data_ready = 1; bus.uart_dout = 8'h4D; bus.rx_ready = 0;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.uart_rdn === 1'b0) cnt_a++;
        end
        check("rd_low_cycles", 32'(cnt_a), 32'd2);
        check("rx_capture", 32'({bus.rx_valid, bus.rx_data}), 32'h14D);
        @(negedge clk);
        bus.uart_data_ready = 0;

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: tbre stuck low after the write
        @(negedge clk);
        bus.rx_ready = 1; bus.tx_req0 = 1; bus.tx_data0 = 8'h2B;
        cnt_a = 0;
        while (bus.tx_ack0 !== 1'b1 && cnt_a < 20) begin
            @(posedge clk);
            #1;
            cnt_a++;
        end
        check("timeout_ack_seen", 32'(bus.tx_ack0), 32'd1);
        bus.tx_req0 = 0; bus.uart_tbre = 0; bus.rx_ready = 0;
        cnt_a = 0;
        while (bus.tx_timeout !== 1'b1 && cnt_a < 5000) begin
            @(posedge clk);
            #1;
            cnt_a++;
        end
        check("timeout_delay", 32'(cnt_a), 32'd4095);
        @(posedge clk);
        #1;
        check("timeout_after", 32'({bus.busy, bus.tx_timeout}), 32'd0);
        bus.uart_tbre = 1;
`endif

        check("wrn_rdn_overlap", 32'(n_overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
